// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared state encodings and constants for the signed divide sequencer
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } div_state_e;

    localparam int          DIV_ITER = 32;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // The only signed quotient that does not fit: INT_MIN / -1.
    function automatic logic is_overflow(input logic [31:0] a, input logic [31:0] b);
        return (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/div_reg.sv
// rtl/div_reg.sv - enabled register with synchronous clear; clear wins over enable
module div_reg #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's complement negation (magnitude in, sign-corrected out)
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] value_o
);

    assign value_o = neg_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - control FSM sequencing the 32-iteration restoring divider for signed DIV
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = DIV_ITER,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_start,
    output logic             div_result_rdy,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             result_rdy_q;
    logic             done_q;
    logic             busy_q;

    logic             b_zero;
    logic             last_iter;
    logic             cap_run;
    logic             cap_en;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             ovf_d;
    logic             ovf_q;
    logic             exc_d;
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] rem_d;

    assign b_zero    = (data_operandB == '0);
    assign ovf_d     = is_overflow(data_operandA, data_operandB);
    assign last_iter = (state_q == S_RUN) && (cnt_q == CNT_W'(ITER - 1));
    // A new request in the final RUN cycle aborts, so the stale quotient must not be captured.
    assign cap_run   = last_iter && !ctrl_DIV;
    assign cap_en    = cap_run || (ctrl_DIV && b_zero);
    assign result_d  = cap_run ? quot_fix : '0;
    assign rem_d     = cap_run ? rem_fix  : '0;
    assign exc_d     = cap_run ? ovf_q    : 1'b1;

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
        .value_i (data_operandA),
        .neg_i   (data_operandA[WIDTH-1]),
        .value_o (mag_a_d)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
        .value_i (data_operandB),
        .neg_i   (data_operandB[WIDTH-1]),
        .value_o (mag_b_d)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_quot_fix (
        .value_i (div_quotient),
        .neg_i   (sign_a_q ^ sign_b_q),
        .value_o (quot_fix)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .value_i (div_remainder),
        .neg_i   (sign_a_q),
        .value_o (rem_fix)
    );

    div_reg #(.W(1)) u_sign_a (
        .clock (clock), .clr (reset), .en (ctrl_DIV),
        .d (data_operandA[WIDTH-1]), .q (sign_a_q)
    );

    div_reg #(.W(1)) u_sign_b (
        .clock (clock), .clr (reset), .en (ctrl_DIV),
        .d (data_operandB[WIDTH-1]), .q (sign_b_q)
    );

    div_reg #(.W(1)) u_ovf (
        .clock (clock), .clr (reset), .en (ctrl_DIV),
        .d (ovf_d), .q (ovf_q)
    );

    div_reg #(.W(WIDTH)) u_dividend (
        .clock (clock), .clr (reset), .en (ctrl_DIV),
        .d (mag_a_d), .q (div_dividend)
    );

    div_reg #(.W(WIDTH)) u_divisor (
        .clock (clock), .clr (reset), .en (ctrl_DIV),
        .d (mag_b_d), .q (div_divisor)
    );

    div_reg #(.W(WIDTH)) u_result (
        .clock (clock), .clr (reset), .en (cap_en),
        .d (result_d), .q (data_result)
    );

    div_reg #(.W(WIDTH)) u_remainder (
        .clock (clock), .clr (reset), .en (cap_en),
        .d (rem_d), .q (data_remainder)
    );

    div_reg #(.W(1)) u_exception (
        .clock (clock), .clr (reset), .en (cap_en),
        .d (exc_d), .q (data_exception)
    );

    // Every strobe is registered against the state being entered, so it is high exactly
    // while the FSM sits in that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            result_rdy_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else if (ctrl_DIV) begin
            cnt_q        <= '0;
            result_rdy_q <= 1'b0;
            if (b_zero) begin
                state_q <= S_DONE;
                start_q <= 1'b0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                state_q <= S_START;
                start_q <= 1'b1;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
            end
        end else begin
            case (state_q)
                S_START: begin
                    state_q      <= S_RUN;
                    cnt_q        <= '0;
                    start_q      <= 1'b0;
                    result_rdy_q <= (ITER == 1);
                    busy_q       <= 1'b1;
                end
                S_RUN: begin
                    if (last_iter) begin
                        state_q      <= S_DONE;
                        cnt_q        <= '0;
                        result_rdy_q <= 1'b0;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q        <= cnt_q + CNT_W'(1);
                        result_rdy_q <= (cnt_q == CNT_W'(ITER - 2));
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div_start      = start_q;
    assign div_result_rdy = result_rdy_q;
    assign data_resultRDY = done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - randomized self-checking bench for div_sequencer with a behavioural divider
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_start;
    logic        div_result_rdy;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          n_start = 0;
    int          n_rr = 0;
    int          n_rdy = 0;
    logic [31:0] noise = '0;

    div_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_start      (div_start),
        .div_result_rdy (div_result_rdy),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Unsigned divider stand-in: answers only while result_rdy is high, garbage otherwise.
    always_comb begin
        div_quotient  = noise;
        div_remainder = ~noise;
        if (div_result_rdy && div_divisor != 0) begin
            div_quotient  = div_dividend / div_divisor;
            div_remainder = div_dividend % div_divisor;
        end
    end

    always @(posedge clock) noise <= $urandom;

    always @(negedge clock) begin
        if (div_start)      n_start <= n_start + 1;
        if (div_result_rdy) n_rr    <= n_rr + 1;
        if (data_resultRDY) n_rdy   <= n_rdy + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic e);
        if (b == 0) begin
            q = 0; r = 0; e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return ($signed(v) < 0) ? 32'(-$signed(v)) : v;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV = 1'b1; data_operandA = a; data_operandB = b;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
    endtask

    // Waits for resultRDY after an accepted request and checks everything about that op.
    task automatic finish_op(input logic [31:0] a, input logic [31:0] b,
                             input int s0, input int r0, input int p0, input int starts);
        logic [31:0] eq, er;
        logic        ee;
        int          k;
        model(a, b, eq, er, ee);
        k = 0;
        while (!data_resultRDY && k < 60) begin
            if (k == 5 && b != 0) check("busy_mid_op", busy, 1);
            if (div_result_rdy) check("dividend_held", div_dividend, magnitude(a));
            @(posedge clock); #1;
            k++;
        end
        check("edges_to_result", k, (b == 0) ? 0 : 33);
        check("result", data_result, eq);
        check("remainder", data_remainder, er);
        check("exception", data_exception, ee);
        @(posedge clock); #1;
        check("rdy_one_cycle", data_resultRDY, 0);
        check("result_held", data_result, eq);
        check("start_pulses", n_start - s0, (b == 0) ? 0 : starts);
        check("iter_rdy_pulses", n_rr - r0, (b == 0) ? 0 : 1);
        check("result_pulses", n_rdy - p0, 1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        int s0, r0, p0;
        s0 = n_start; r0 = n_rr; p0 = n_rdy;
        issue(a, b);
        finish_op(a, b, s0, r0, p0, 1);
    endtask

    initial begin
        int s0, r0, p0;
        logic [31:0] a, b;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", data_result, 0);
        check("rst_remainder", data_remainder, 0);
        check("rst_exception", data_exception, 0);
        check("rst_resultRDY", data_resultRDY, 0);
        check("rst_busy", busy, 0);
        check("rst_start", div_start, 0);
        check("rst_dividend", div_dividend, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        do_op(32'd100, 32'd7);
        do_op(-32'sd100, 32'd7);
        do_op(32'd100, -32'sd7);
        do_op(-32'sd100, -32'sd7);
        do_op(32'd5, 32'd0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF);
        do_op(32'h8000_0000, 32'd1);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) b = 0;
            if ($urandom_range(0, 1) == 0) b = -b;
            do_op(a, b);
        end

        s0 = n_start; r0 = n_rr; p0 = n_rdy;
        issue(32'd50, 32'd5);
        repeat (11) begin @(posedge clock); #1; end
        issue(32'd9, 32'd2);
        finish_op(32'd9, 32'd2, s0, r0, p0, 2);

        p0 = n_rdy;
        issue(32'd50, 32'd5);
        repeat (21) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_result", data_result, 0);
        check("midrst_remainder", data_remainder, 0);
        check("midrst_divisor", div_divisor, 0);
        repeat (40) begin @(posedge clock); #1; end
        check("midrst_no_rdy", n_rdy - p0, 0);
        do_op(32'd7, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
